branch_predict_unit: RTL and testbench

Fetch-side consumer of the branch target buffer. Each cycle it drives the buffer's read index from the IF PC and checks the returned tag and valid bit. It combines these with a per-entry 2-bit saturating direction counter to produce the predicted next PC. It records every prediction in an in-order in-flight queue. When the instruction leaves MEM it checks the prediction against the actual outcome and raises mispredict with the corrected PC.

---
 rtl/branch_predict_types_pkg.sv | 31 +++
 rtl/branch_predict_unit_if.sv | 14 +
 rtl/pred_fifo.sv | 55 +++++
 rtl/branch_predict_unit.sv | 86 ++++++++
 tb/tb_branch_predict_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_predict_types_pkg.sv
// Shared types for the fetch-side branch predictor: PC field layout, counter
// width and the in-flight prediction record.
package branch_predict_types_pkg;

  localparam int PC_W  = 32;
  localparam int OFF_W = 2;
  localparam int IDX_W = 2;
  localparam int TAG_W = PC_W - IDX_W - OFF_W;

  typedef logic [PC_W-1:0]  pc_t;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [IDX_W-1:0] index_t;
  typedef logic [1:0]       counter_t;

  typedef struct packed {
    logic predtaken;
    pc_t  predpc;
  } pred_entry_t;

  // Weakly not-taken.
  localparam counter_t CNT_INIT = 2'b01;

  function automatic tag_t pc_tag(input pc_t pc);
    return pc[PC_W-1:IDX_W+OFF_W];
  endfunction

  function automatic index_t pc_index(input pc_t pc);
    return pc[IDX_W+OFF_W-1:OFF_W];
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Read port of the branch target buffer: index out, target/tag/valid back
// in the same cycle.
interface branch_predict_unit_if;
  import branch_predict_types_pkg::*;

  index_t IFpcindex;
  pc_t    PRbpc;
  tag_t   PRtag;
  logic   PRvalid;

  modport master (output IFpcindex, input PRbpc, PRtag, PRvalid);
  modport slave  (input IFpcindex, output PRbpc, PRtag, PRvalid);

endinterface

// File: rtl/pred_fifo.sv
// In-order queue of predictions between IF and MEM. Push/pop are qualified
// internally against full/empty; clear wins over both.
module pred_fifo
  import branch_predict_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  pred_entry_t                wdata,
  output pred_entry_t                head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  pred_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] rdptr;
  logic [PTR_W-1:0] wrptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rdptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rdptr <= '0;
      wrptr <= '0;
      count <= '0;
    end else if (clear) begin
      rdptr <= '0;
      wrptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wrptr <= wrptr + 1'b1;
      if (do_pop)  rdptr <= rdptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Payload storage carries no reset; count gates its visibility.
  always_ff @(posedge CLK) begin
    if (do_push && !clear) mem[wrptr] <= wdata;
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-side predictor: BTB hit + 2-bit direction counters produce the next
// PC; predictions are queued until MEM and verified there.
module branch_predict_unit #(
  parameter int                               DEPTH    = 4,
  parameter int                               ENTRIES  = 4,
  parameter branch_predict_types_pkg::counter_t CNT_INIT = branch_predict_types_pkg::CNT_INIT
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [31:0]                  IFpc,
  input  logic                         IFvalid,
  branch_predict_unit_if.master        btb,
  output logic                         predtaken,
  output logic [31:0]                  predpc,
  input  logic                         MMvalid,
  input  logic                         MMbranch,
  input  logic                         MMtaken,
  input  logic [31:0]                  MMpc,
  input  logic [31:0]                  MMtarget,
  input  logic                         flush,
  output logic                         mispredict,
  output logic [31:0]                  fixpc,
  output logic                         qfull
);

  import branch_predict_types_pkg::*;

  localparam int CNT_W = $clog2(DEPTH+1);

  counter_t          cnt [ENTRIES];
  logic              hit;
  logic              push;
  logic              pop;
  logic              clear;
  pred_entry_t       new_entry;
  pred_entry_t       head;
  pred_entry_t       head_pred;
  logic [CNT_W-1:0]  count;
  pc_t               mm_seq;
  pc_t               actual;

  function automatic counter_t sat_step(input counter_t c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'b01;
    else    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Fetch read path: purely combinational against the BTB response.
  assign btb.IFpcindex = pc_index(IFpc);
  assign hit           = btb.PRvalid && (btb.PRtag == pc_tag(IFpc));
  assign predtaken     = hit && cnt[pc_index(IFpc)][1];
  assign predpc        = predtaken ? btb.PRbpc : IFpc + 32'd4;

  assign new_entry = '{predtaken: predtaken, predpc: predpc};
  assign clear     = mispredict || flush;
  assign push      = IFvalid && !qfull && !mispredict && !flush;
  assign pop       = MMvalid && (count != '0);

  pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .nRST  (nRST),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .wdata (new_entry),
    .head  (head),
    .count (count),
    .full  (qfull)
  );

  // MEM check: an empty queue means fetch assumed fall-through.
  assign mm_seq     = MMpc + 32'd4;
  assign head_pred  = (count == '0) ? '{predtaken: 1'b0, predpc: mm_seq} : head;
  assign actual     = (MMbranch && MMtaken) ? MMtarget : mm_seq;
  assign mispredict = MMvalid && (actual != head_pred.predpc);
  assign fixpc      = mispredict ? actual : mm_seq;

  // Training uses the resolved direction regardless of the prediction outcome.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) cnt[i] <= CNT_INIT;
    end else if (MMvalid && MMbranch) begin
      cnt[pc_index(MMpc)] <= sat_step(cnt[pc_index(MMpc)], MMtaken);
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: queue/array reference model checked
// every cycle, plus literal expectations along the directed sequence.
module tb_branch_predict_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] IFpc;
  logic        IFvalid;
  logic        predtaken;
  logic [31:0] predpc;
  logic        MMvalid, MMbranch, MMtaken;
  logic [31:0] MMpc, MMtarget;
  logic        flush;
  logic        mispredict;
  logic [31:0] fixpc;
  logic        qfull;

  branch_predict_unit_if bif();

  branch_predict_unit dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .IFpc       (IFpc),
    .IFvalid    (IFvalid),
    .btb        (bif),
    .predtaken  (predtaken),
    .predpc     (predpc),
    .MMvalid    (MMvalid),
    .MMbranch   (MMbranch),
    .MMtaken    (MMtaken),
    .MMpc       (MMpc),
    .MMtarget   (MMtarget),
    .flush      (flush),
    .mispredict (mispredict),
    .fixpc      (fixpc),
    .qfull      (qfull)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of predicted next-PCs and an array of counters.
  typedef struct { logic t; logic [31:0] pc; } ent_t;
  ent_t mq[$];
  int   mcnt[4];

  function automatic logic m_taken();
    return bif.PRvalid && (bif.PRtag == IFpc[31:4]) && (mcnt[IFpc[3:2]] >= 2);
  endfunction

  function automatic logic [31:0] m_predpc();
    return m_taken() ? bif.PRbpc : IFpc + 32'd4;
  endfunction

  function automatic logic [31:0] m_actual();
    return (MMbranch && MMtaken) ? MMtarget : MMpc + 32'd4;
  endfunction

  function automatic logic m_mis();
    logic [31:0] hp;
    hp = (mq.size() == 0) ? MMpc + 32'd4 : mq[0].pc;
    return MMvalid && (m_actual() != hp);
  endfunction

  always @(posedge CLK or negedge nRST) begin : model_upd
    logic mis, pushok, popok;
    ent_t e;
    if (!nRST) begin
      mq.delete();
      foreach (mcnt[i]) mcnt[i] = 1;
    end else begin
      mis    = m_mis();
      pushok = IFvalid && (mq.size() < 4) && !mis && !flush;
      popok  = MMvalid && (mq.size() != 0);
      e      = '{m_taken(), m_predpc()};
      if (MMvalid && MMbranch) begin
        if (MMtaken) mcnt[MMpc[3:2]] = (mcnt[MMpc[3:2]] == 3) ? 3 : mcnt[MMpc[3:2]] + 1;
        else         mcnt[MMpc[3:2]] = (mcnt[MMpc[3:2]] == 0) ? 0 : mcnt[MMpc[3:2]] - 1;
      end
      if (mis || flush) mq.delete();
      else begin
        if (popok)  void'(mq.pop_front());
        if (pushok) mq.push_back(e);
      end
    end
  end

  always @(negedge CLK) begin
    chk("m_predtaken", {31'd0, predtaken}, {31'd0, m_taken()});
    chk("m_predpc", predpc, m_predpc());
    chk("m_pcindex", {30'd0, bif.IFpcindex}, {30'd0, IFpc[3:2]});
    chk("m_mispredict", {31'd0, mispredict}, {31'd0, m_mis()});
    chk("m_qfull", {31'd0, qfull}, {31'd0, mq.size() == 4});
    if (m_mis()) chk("m_fixpc", fixpc, m_actual());
  end

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic mm(input logic v, input logic b, input logic t, input logic [31:0] pc, input logic [31:0] tg);
    MMvalid = v; MMbranch = b; MMtaken = t; MMpc = pc; MMtarget = tg;
  endtask

  task automatic pr(input logic v, input logic [27:0] tag, input logic [31:0] bpc);
    bif.PRvalid = v; bif.PRtag = tag; bif.PRbpc = bpc;
  endtask

  initial begin
    nRST = 1'b1; IFpc = 32'h40; IFvalid = 1'b0; flush = 1'b0;
    mm(0, 0, 0, 32'h0, 32'h0);
    pr(0, 28'h0, 32'h0);
    #1 nRST = 1'b0;

    // Reset state
    @(negedge CLK);
    chk("rst_predtaken", {31'd0, predtaken}, 32'd0);
    chk("rst_predpc", predpc, 32'h44);
    chk("rst_qfull", {31'd0, qfull}, 32'd0);
    #2 nRST = 1'b1;
    nxt();

    // 1: miss, then not-taken branch from an empty queue
    @(negedge CLK);
    chk("t1_predpc", predpc, 32'h44);
    nxt();
    mm(1, 1, 0, 32'h40, 32'h100);
    @(negedge CLK);
    chk("t1_mispredict", {31'd0, mispredict}, 32'd0);
    nxt();

    // 2: train taken (counter 00 -> 11), then hit
    mm(1, 1, 1, 32'h40, 32'h100);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("t2_train_mis", {31'd0, mispredict}, 32'd1);
      chk("t2_train_fix", fixpc, 32'h100);
      nxt();
    end
    mm(0, 0, 0, 32'h0, 32'h0);
    pr(1, 28'h4, 32'h100);
    IFpc = 32'h40; IFvalid = 1'b1;
    @(negedge CLK);
    chk("t2_predtaken", {31'd0, predtaken}, 32'd1);
    chk("t2_predpc", predpc, 32'h100);
    nxt();

    // 3: tag mismatch on the same index
    IFvalid = 1'b0; IFpc = 32'h80;
    @(negedge CLK);
    chk("t3_predtaken", {31'd0, predtaken}, 32'd0);
    chk("t3_predpc", predpc, 32'h84);
    nxt();

    // 4: head {1,0x100} resolves not-taken; same-cycle push must be dropped
    IFvalid = 1'b1; IFpc = 32'h44; pr(0, 28'h0, 32'h0);
    mm(1, 1, 0, 32'h40, 32'h100);
    @(negedge CLK);
    chk("t4_mispredict", {31'd0, mispredict}, 32'd1);
    chk("t4_fixpc", fixpc, 32'h44);
    nxt();
    IFvalid = 1'b0;
    mm(1, 0, 0, 32'h200, 32'h0);
    @(negedge CLK);
    chk("t4_empty_after", {31'd0, mispredict}, 32'd0);
    chk("t4_qfull", {31'd0, qfull}, 32'd0);
    nxt();
    mm(1, 1, 1, 32'h40, 32'h100);
    @(negedge CLK);
    chk("t4_retrain_mis", {31'd0, mispredict}, 32'd1);
    nxt();

    // 5: fill, overflow push, then steady pop+push across the wrap
    mm(0, 0, 0, 32'h0, 32'h0);
    IFvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      IFpc = 32'h1000 + 32'(4 * i);
      @(negedge CLK);
      chk("t5_fill_qfull", {31'd0, qfull}, 32'd0);
      nxt();
    end
    IFpc = 32'h1010;
    @(negedge CLK);
    chk("t5_full", {31'd0, qfull}, 32'd1);
    nxt();
    IFvalid = 1'b0;
    mm(1, 0, 0, 32'h1000, 32'h0);
    @(negedge CLK);
    chk("t5_pop0", {31'd0, mispredict}, 32'd0);
    nxt();
    IFvalid = 1'b1;
    for (int j = 0; j < 6; j++) begin
      IFpc = 32'h2000 + 32'(4 * j);
      MMpc = (j < 3) ? 32'h1004 + 32'(4 * j) : 32'h2000 + 32'(4 * (j - 3));
      @(negedge CLK);
      chk("t5_order", {31'd0, mispredict}, 32'd0);
      nxt();
    end

    // 6: asynchronous reset with three predictions in flight
    IFvalid = 1'b0; mm(0, 0, 0, 32'h0, 32'h0);
    IFpc = 32'h40; pr(1, 28'h4, 32'h100);
    @(negedge CLK);
    chk("t6_pre_taken", {31'd0, predtaken}, 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("t6_rst_taken", {31'd0, predtaken}, 32'd0);
    chk("t6_rst_predpc", predpc, 32'h44);
    chk("t6_rst_qfull", {31'd0, qfull}, 32'd0);
    nxt();
    nRST = 1'b1;
    mm(1, 0, 0, 32'h300, 32'h0);
    @(negedge CLK);
    chk("t6_empty", {31'd0, mispredict}, 32'd0);
    chk("t6_cnt_init", {31'd0, predtaken}, 32'd0);
    nxt();
    mm(1, 1, 1, 32'h40, 32'h100);
    nxt();
    mm(0, 0, 0, 32'h0, 32'h0);
    @(negedge CLK);
    chk("t6_cnt_10", {31'd0, predtaken}, 32'd1);
    nxt();

    // Flush discards in-flight work and the same-cycle push
    IFvalid = 1'b1; IFpc = 32'h500;
    nxt();
    flush = 1'b1; IFpc = 32'h504;
    nxt();
    flush = 1'b0; IFvalid = 1'b0;
    mm(1, 0, 0, 32'h600, 32'h0);
    @(negedge CLK);
    chk("flush_empty", {31'd0, mispredict}, 32'd0);
    nxt();
    mm(0, 0, 0, 32'h0, 32'h0);
    nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
